// File: rtl/pc_sequencer.sv
// Program counter and HALT/FETCH/EXEC/MCWAIT run control for picoMIPS; one instruction per FETCH_LAT+1 cycles.
// No backpressure: MCWAIT stalls indefinitely on mc_done, and exec_en/mc_start are combinational from state.
module pc_sequencer #(
    parameter int PSIZE      = 6,
    parameter int FETCH_LAT  = 1,
    parameter int AUTO_START = 1,
    parameter int ICNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              step,
    input  logic              halt_req,
    input  logic              PC_incr,
    input  logic              PC_abs_branch,
    input  logic              PC_rel_branch,
    input  logic [PSIZE-1:0]  branch_val,
    input  logic              mc_req,
    input  logic              mc_done,
    output logic [PSIZE-1:0]  PC,
    output logic              exec_en,
    output logic              mc_start,
    output logic              running,
    output logic [ICNT_W-1:0] icount
);

    typedef enum logic [1:0] {
        S_HALT   = 2'd0,
        S_FETCH  = 2'd1,
        S_EXEC   = 2'd2,
        S_MCWAIT = 2'd3
    } state_t;

    localparam logic [2:0] FETCH_LAST = 3'(FETCH_LAT - 1);
    localparam state_t     RST_STATE  = (AUTO_START != 0) ? S_FETCH : S_HALT;
    localparam logic       RST_RUN    = (AUTO_START != 0);

    state_t             state_q, state_d;
    logic [PSIZE-1:0]   pc_d;
    logic               run_mode_q, run_mode_d;
    logic               halt_pend_q, halt_pend_d;
    logic [2:0]         fcnt_q, fcnt_d;

    always_comb begin
        state_d     = state_q;
        pc_d        = PC;
        run_mode_d  = run_mode_q;
        halt_pend_d = halt_pend_q;
        fcnt_d      = fcnt_q;
        exec_en     = 1'b0;
        mc_start    = 1'b0;

        if (state_q != S_HALT && halt_req) begin
            halt_pend_d = 1'b1;
        end

        case (state_q)
            S_HALT: begin
                if (start) begin
                    state_d    = S_FETCH;
                    run_mode_d = 1'b1;
                end else if (step) begin
                    state_d    = S_FETCH;
                    run_mode_d = 1'b0;
                end
            end
            S_FETCH: begin
                if (fcnt_q == FETCH_LAST) begin
                    fcnt_d  = 3'd0;
                    state_d = S_EXEC;
                end else begin
                    fcnt_d = fcnt_q + 3'd1;
                end
            end
            S_EXEC: begin
                if (mc_req) begin
                    mc_start = 1'b1;
                    state_d  = S_MCWAIT;
                end else begin
                    exec_en = 1'b1;
                    if (PC_abs_branch) begin
                        pc_d = branch_val;
                    end else if (PC_rel_branch) begin
                        pc_d = PC + branch_val;
                    end else if (PC_incr) begin
                        pc_d = PC + PSIZE'(1);
                    end
                end
            end
            S_MCWAIT: begin
                // Multi-cycle ops always fall through to the next address.
                if (mc_done) begin
                    exec_en = 1'b1;
                    pc_d    = PC + PSIZE'(1);
                end
            end
            default: state_d = S_HALT;
        endcase

        // A halt request landing on the commit cycle still stops after this instruction.
        if (exec_en) begin
            if (halt_pend_q || halt_req || !run_mode_q) begin
                state_d     = S_HALT;
                halt_pend_d = 1'b0;
            end else begin
                state_d = S_FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= RST_STATE;
            PC          <= '0;
            icount      <= '0;
            run_mode_q  <= RST_RUN;
            halt_pend_q <= 1'b0;
            fcnt_q      <= 3'd0;
        end else begin
            state_q     <= state_d;
            PC          <= pc_d;
            run_mode_q  <= run_mode_d;
            halt_pend_q <= halt_pend_d;
            fcnt_q      <= fcnt_d;
            if (exec_en) begin
                icount <= icount + ICNT_W'(1);
            end
        end
    end

    assign running = (state_q != S_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: dut0 uses AUTO_START=1/FETCH_LAT=1, dut1 uses AUTO_START=0/FETCH_LAT=3.
// Only one DUT is active at a time; the other is held in reset.
module tb_pc_sequencer;

    typedef struct packed {
        logic       rst_n;
        logic       start;
        logic       step;
        logic       hreq;
        logic       incr;
        logic       abs_b;
        logic       rel_b;
        logic [5:0] bval;
        logic       mcr;
        logic       mcd;
    } in_t;

    typedef struct {
        logic        sel;
        in_t         in;
        logic [5:0]  pc;
        logic        ex;
        logic        mcs;
        logic        run;
        logic [15:0] ic;
    } vec_t;

    localparam logic [5:0] M3 = 6'b111101;

    logic        clk = 1'b0;
    in_t         in0 = '0;
    in_t         in1 = '0;
    logic [5:0]  pc0, pc1;
    logic        ex0, ex1, mcs0, mcs1, run0, run1;
    logic [15:0] ic0, ic1;

    int checks   = 0;
    int failures = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    pc_sequencer #(.PSIZE(6), .FETCH_LAT(1), .AUTO_START(1), .ICNT_W(16)) dut0 (
        .clk(clk), .reset(in0.rst_n), .start(in0.start), .step(in0.step), .halt_req(in0.hreq),
        .PC_incr(in0.incr), .PC_abs_branch(in0.abs_b), .PC_rel_branch(in0.rel_b),
        .branch_val(in0.bval), .mc_req(in0.mcr), .mc_done(in0.mcd),
        .PC(pc0), .exec_en(ex0), .mc_start(mcs0), .running(run0), .icount(ic0)
    );

    pc_sequencer #(.PSIZE(6), .FETCH_LAT(3), .AUTO_START(0), .ICNT_W(16)) dut1 (
        .clk(clk), .reset(in1.rst_n), .start(in1.start), .step(in1.step), .halt_req(in1.hreq),
        .PC_incr(in1.incr), .PC_abs_branch(in1.abs_b), .PC_rel_branch(in1.rel_b),
        .branch_val(in1.bval), .mc_req(in1.mcr), .mc_done(in1.mcd),
        .PC(pc1), .exec_en(ex1), .mc_start(mcs1), .running(run1), .icount(ic1)
    );

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    // add(sel, rst_n,start,step,hreq, incr,abs,rel, bval, mc_req,mc_done, exp pc,exec_en,mc_start,running,icount)
    task automatic add(input logic s, input logic r, input logic st, input logic sp, input logic hq,
                       input logic inc, input logic ab, input logic rl, input logic [5:0] bv,
                       input logic mr, input logic md, input logic [5:0] epc, input logic eex,
                       input logic emcs, input logic erun, input logic [15:0] eic);
        vec_t v;
        v.sel = s;
        v.in  = '{r, st, sp, hq, inc, ab, rl, bv, mr, md};
        v.pc  = epc;
        v.ex  = eex;
        v.mcs = emcs;
        v.run = erun;
        v.ic  = eic;
        vq.push_back(v);
    endtask

    initial begin
        logic [5:0]  a_pc;
        logic        a_ex, a_mcs, a_run;
        logic [15:0] a_ic;
        int          n;
        logic        seen;

        // dut0: reset, then continuous run with PC_incr held
        add(0, 0,0,0,0, 0,0,0, 0,  0,0,  0,0,0,0,0);
        add(0, 0,0,0,0, 0,0,0, 0,  0,0,  0,0,0,0,0);
        add(0, 1,0,0,0, 1,0,0, 0,  0,0,  0,0,0,1,0);
        add(0, 1,0,0,0, 1,0,0, 0,  0,0,  0,1,0,1,0);
        add(0, 1,0,0,0, 1,0,0, 0,  0,0,  1,0,0,1,1);
        add(0, 1,0,0,0, 1,0,0, 0,  0,0,  1,1,0,1,1);
        add(0, 1,0,0,0, 1,0,0, 0,  0,0,  2,0,0,1,2);
        add(0, 1,0,0,0, 1,0,0, 0,  0,0,  2,1,0,1,2);
        add(0, 1,0,0,0, 1,0,0, 0,  0,0,  3,0,0,1,3);
        // branches: abs to 5, rel -3 to 2, rel -3 wraps to 63, incr wraps to 0, abs beats rel
        add(0, 1,0,0,0, 0,1,0, 5,  0,0,  3,1,0,1,3);
        add(0, 1,0,0,0, 0,0,1, M3, 0,0,  5,0,0,1,4);
        add(0, 1,0,0,0, 0,0,1, M3, 0,0,  5,1,0,1,4);
        add(0, 1,0,0,0, 0,0,1, M3, 0,0,  2,0,0,1,5);
        add(0, 1,0,0,0, 0,0,1, M3, 0,0,  2,1,0,1,5);
        add(0, 1,0,0,0, 0,0,0, 0,  0,0, 63,0,0,1,6);
        add(0, 1,0,0,0, 1,0,0, 0,  0,0, 63,1,0,1,6);
        add(0, 1,0,0,0, 0,0,0, 0,  0,0,  0,0,0,1,7);
        add(0, 1,0,0,0, 1,1,1, 9,  0,0,  0,1,0,1,7);
        add(0, 1,0,0,0, 0,0,0, 0,  0,0,  9,0,0,1,8);
        add(0, 1,0,0,0, 0,0,0, 0,  0,0,  9,1,0,1,8);
        add(0, 1,0,0,0, 0,0,0, 0,  0,0,  9,0,0,1,9);
        // multi-cycle: launch, 5 wait cycles, done pulse ignores branch strobes
        add(0, 1,0,0,0, 1,0,0, 0,  1,0,  9,0,1,1,9);
        for (int k = 0; k < 5; k++) add(0, 1,0,0,0, 1,0,0, 0, 1,0, 9,0,0,1,9);
        add(0, 1,0,0,0, 0,1,0, 30, 0,1,  9,1,0,1,9);
        // halt_req mid-FETCH, halt_req ignored in HALT, single step, start+step
        add(0, 1,0,0,1, 0,0,0, 0,  0,0, 10,0,0,1,10);
        add(0, 1,0,0,0, 1,0,0, 0,  0,0, 10,1,0,1,10);
        add(0, 1,0,0,1, 1,0,0, 0,  0,0, 11,0,0,0,11);
        add(0, 1,0,1,0, 1,0,0, 0,  0,0, 11,0,0,0,11);
        add(0, 1,0,0,0, 1,0,0, 0,  0,0, 11,0,0,1,11);
        add(0, 1,0,0,0, 1,0,0, 0,  0,0, 11,1,0,1,11);
        add(0, 1,0,0,0, 1,0,0, 0,  0,0, 12,0,0,0,12);
        add(0, 1,1,1,0, 1,0,0, 0,  0,0, 12,0,0,0,12);
        add(0, 1,0,0,0, 1,0,0, 0,  0,0, 12,0,0,1,12);
        add(0, 1,0,0,0, 1,0,0, 0,  0,0, 12,1,0,1,12);
        add(0, 1,0,0,0, 1,0,0, 0,  0,0, 13,0,0,1,13);
        add(0, 1,0,0,0, 1,0,0, 0,  0,0, 13,1,0,1,13);
        add(0, 1,0,0,0, 1,0,0, 0,  0,0, 14,0,0,1,14);

        // dut1: halted after reset, start, exec every 4th cycle, halt_req on commit
        add(1, 1,0,0,0, 1,0,0, 0,  0,0,  0,0,0,0,0);
        add(1, 1,1,0,0, 1,0,0, 0,  0,0,  0,0,0,0,0);
        for (int k = 0; k < 3; k++) add(1, 1,0,0,0, 1,0,0, 0, 0,0, 0,0,0,1,0);
        add(1, 1,0,0,0, 1,0,0, 0,  0,0,  0,1,0,1,0);
        for (int k = 0; k < 3; k++) add(1, 1,0,0,0, 1,0,0, 0, 0,0, 1,0,0,1,1);
        add(1, 1,0,0,0, 1,0,0, 0,  0,0,  1,1,0,1,1);
        for (int k = 0; k < 3; k++) add(1, 1,0,0,0, 1,0,0, 0, 0,0, 2,0,0,1,2);
        add(1, 1,0,0,1, 1,0,0, 0,  0,0,  2,1,0,1,2);
        add(1, 1,0,0,0, 1,0,0, 0,  0,0,  3,0,0,0,3);
        add(1, 1,0,0,0, 1,0,0, 0,  0,0,  3,0,0,0,3);

        foreach (vq[i]) begin
            @(negedge clk);
            if (vq[i].sel) begin
                in0 = '0;
                in1 = vq[i].in;
            end else begin
                in0 = vq[i].in;
                in1 = '0;
            end
            #1;
            if (vq[i].in.rst_n) begin
                a_pc  = vq[i].sel ? pc1  : pc0;
                a_ex  = vq[i].sel ? ex1  : ex0;
                a_mcs = vq[i].sel ? mcs1 : mcs0;
                a_run = vq[i].sel ? run1 : run0;
                a_ic  = vq[i].sel ? ic1  : ic0;
                chk("pc",       i, 32'(a_pc),  32'(vq[i].pc));
                chk("exec_en",  i, 32'(a_ex),  32'(vq[i].ex));
                chk("mc_start", i, 32'(a_mcs), 32'(vq[i].mcs));
                chk("running",  i, 32'(a_run), 32'(vq[i].run));
                chk("icount",   i, 32'(a_ic),  32'(vq[i].ic));
            end
        end

        // dut1: single step into a multi-cycle op, then reset while in MCWAIT
        @(negedge clk);
        in1 = '0;
        in1.rst_n = 1'b1;
        in1.step  = 1'b1;
        in1.mcr   = 1'b1;
        #1;
        chk("step_halted", 0, 32'(run1), 32'd0);
        seen = 1'b0;
        n = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            in1.step = 1'b0;
            #1;
            n++;
            seen = mcs1;
        end
        chk("mc_start_seen", 0, 32'(seen), 32'd1);
        chk("mc_start_lat",  0, 32'(n),    32'd4);
        chk("mc_pc",         0, 32'(pc1),  32'd3);
        chk("mc_exec_en",    0, 32'(ex1),  32'd0);

        @(negedge clk);
        #1;
        chk("mcwait_mc_start", 0, 32'(mcs1), 32'd0);
        chk("mcwait_exec_en",  0, 32'(ex1),  32'd0);
        chk("mcwait_running",  0, 32'(run1), 32'd1);

        @(negedge clk);
        in1.rst_n = 1'b0;
        #1;
        chk("rst_mcwait_exec_en", 0, 32'(ex1), 32'd0);

        @(negedge clk);
        in1.rst_n = 1'b1;
        in1.mcd   = 1'b1;
        #1;
        chk("post_rst_running", 0, 32'(run1), 32'd0);
        chk("post_rst_pc",      0, 32'(pc1),  32'd0);
        chk("post_rst_icount",  0, 32'(ic1),  32'd0);
        chk("post_rst_exec_en", 0, 32'(ex1),  32'd0);

        @(negedge clk);
        in1.mcd = 1'b0;
        #1;
        chk("post_rst_hold", 0, 32'(run1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter owner and run-control sequencer for the picoMIPS core. It holds the PC and steps it through FETCH / EXEC (and a multi-cycle wait) according to the decoder's PC_incr / PC_abs_branch / PC_rel_branch strobes. It produces the single-cycle execute strobe that gates register-file writes, and provides run, halt and single-step control for debug and bring-up.

Parameters:
PSIZE, 6, PC / program-address width in bits
FETCH_LAT, 1, instruction-memory wait cycles per fetch; legal range 1..7
AUTO_START, 1, 1 = begin executing from PC 0 after reset; 0 = stay halted after reset
ICNT_W, 16, width of the retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous reset, active-low
start  in  1  level; in HALT, enter continuous run
step  in  1  level; in HALT, execute exactly one instruction, then return to HALT
halt_req  in  1  pulse; stop at the next instruction boundary
PC_incr  in  1  decoder: PC <= PC+1
PC_abs_branch  in  1  decoder: PC <= branch_val
PC_rel_branch  in  1  decoder: PC <= PC + signed(branch_val)
branch_val  in  PSIZE  absolute target or two's-complement relative offset
mc_req  in  1  decoder: current instruction is multi-cycle
mc_done  in  1  multi-cycle unit finished (single-cycle pulse or level)
PC  out  PSIZE  current program address
exec_en  out  1  commit strobe; register-file write = we & exec_en
mc_start  out  1  one-cycle launch pulse to the multi-cycle unit
running  out  1  high when state != HALT
icount  out  ICNT_W  retired-instruction count

Behaviour:
- Reset (reset==0 at a clk edge):
  - PC=0, icount=0, halt_pend=0, run_mode=AUTO_START, fetch counter=0.
  - state = FETCH if AUTO_START=1, else HALT.
  - exec_en=0 and mc_start=0 in the cycle after reset.
  - Reset mid-operation (including during MCWAIT) abandons the instruction with no commit.
- HALT state:
  - PC holds. start → FETCH with run_mode=1. Otherwise step → FETCH with run_mode=0.
  - start has priority over step when both are asserted.
  - halt_req is ignored while in HALT.
- FETCH state:
  - Stays exactly FETCH_LAT cycles; the counter clears on exit.
  - Then → EXEC. Decoder inputs are not sampled in FETCH.
- EXEC state (one cycle; decoder inputs sampled):
  - If mc_req=1: mc_start=1, exec_en=0, PC holds, → MCWAIT.
  - Else exec_en=1 and the PC updates with priority abs > rel > incr. If no strobe is asserted, PC holds (NOP-safe).
- MCWAIT state:
  - Waits indefinitely while mc_done=0; mc_start stays 0.
  - On mc_done=1: exec_en=1 and PC <= PC+1 (multi-cycle ops never branch); continue as for end of EXEC.
- End of instruction (EXEC commit or MCWAIT commit):
  - If halt_pend=1 or run_mode=0 → HALT and clear halt_pend; else → FETCH.
- halt_req handling:
  - Sets sticky halt_pend in any non-HALT state.
  - If halt_req arrives in the same cycle as the commit, that commit goes to HALT.
- Output timing:
  - exec_en and mc_start are combinational from state, mc_req and mc_done.
  - PC, icount and state are registered; start, step and halt_req are sampled only at clk edges.
- Arithmetic:
  - PC arithmetic is modulo 2^PSIZE: 63+1=0; PC 2 + rel -3 = 63 (PSIZE=6).
  - icount increments on every exec_en cycle and wraps at 2^ICNT_W.
- Throughput: FETCH_LAT+1 cycles per single-cycle instruction.

Test Plan:
- AUTO_START=1, FETCH_LAT=1, decoder holds PC_incr=1 → PC 0,1,2,3 on exec cycles 2,4,6; icount=3 after 6 cycles; running=1.
- PC=5, EXEC with PC_rel_branch=1, branch_val=6'b111101 (-3) → PC=2. PC=63 with PC_incr → PC=0. PC_abs_branch and PC_rel_branch both set, branch_val=9 → PC=9.
- EXEC with mc_req=1 → mc_start high for one cycle, PC holds for 5 wait cycles. mc_done pulse → exec_en=1, PC+1, icount+1.
- halt_req pulsed mid-FETCH → current instruction commits, then HALT, running=0. step=1 one cycle → exactly one more commit, then HALT. start and step together → continuous run.
- AUTO_START=0 → HALT after reset with PC=0; reset=0 asserted during MCWAIT → next cycle state HALT, PC=0, icount=0, no exec_en.
- FETCH_LAT=3 → exec_en asserted every 4th cycle; halt_req concurrent with commit → HALT directly after that commit.
